rom_stream_reader: RTL and testbench
====================================

// Module: rom_stream_reader
// PURPOSE
//  Sequencer in front of single_port_sync_read_ROM: on a start pulse, walks len
//  consecutive ROM addresses from start_addr and drives the ROM read address.
//  Captures the registered ROM data and presents it as a valid/ready stream.
//  A small credit-tracked buffer absorbs the ROM's 1-cycle read latency under
//  backpressure, so no word is ever dropped or duplicated.
// PARAMETERS
//  AW        4  ROM address width (ROM depth = 2**AW)
//  DW        8  ROM data width
//  BUF_DEPTH 4  output buffer entries; must be >= 2 (4 gives full throughput)
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      1-cycle request; sampled only when busy=0
//  start_addr in   AW     first ROM address
//  len        in   AW+1   word count, 0..2**AW
//  busy       out  1      high from accepted start until done
//  done       out  1      1-cycle pulse at end of transfer
//  rom_addr   out  AW     registered address to ROM ad_rd
//  rom_data   in   DW     ROM data_out (valid 1 edge after rom_addr sampled)
//  m_data     out  DW     stream data (buffer head)
//  m_valid    out  1      stream valid
//  m_ready    in   1      stream ready; beat transfers when m_valid & m_ready
//  m_last     out  1      high with the final beat of the transfer
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, busy=0, done=0, rom_addr=0, m_valid=0,
//   m_last=0, buffer/credit/issue/return counters cleared; in-flight ROM data
//   after reset is discarded (return pipe cleared).
//  FSM: IDLE -> RUN on start & len!=0; IDLE -> DONE on start & len==0;
//   RUN -> DONE on handshake of the len-th beat; DONE -> IDLE after 1 cycle.
//   busy=1 in RUN and DONE; done=1 only in DONE. start ignored when busy=1.
//  Issue: at the start-accept edge rom_addr<=start_addr, issue flag set, issued=1.
//   Each later edge in RUN with issued<len and
//   (buf_count + in_flight - pop) < BUF_DEPTH: rom_addr<=rom_addr+1, issue again.
//   pop = m_valid & m_ready this cycle. Otherwise rom_addr holds.
//  Address arithmetic modulo 2**AW: address after 2**AW-1 is 0 (wrap).
//  Return: word issued in cycle c is registered by ROM at end of c and written
//   into the buffer at end of c+1 (1-deep valid pipe tracks in_flight).
//  Latency: start sampled at edge E0 -> m_valid high after E2 (first data).
//   Steady state with m_ready=1 and BUF_DEPTH>=4: one beat per cycle.
//  Buffer: FIFO, in-order; simultaneous write and pop allowed; credit rule
//   guarantees never written when full. m_data/m_last are the head entry.
//  m_last: tagged on the word whose issue index == len.
//  done: asserted the cycle after the last handshake; busy falls with done.
//  len==0: no ROM issue, no m_valid; done pulse in cycle after start.
//  len==2**AW: every address read exactly once, wrapping if start_addr!=0.
// TESTING
//  1 Full sweep: start_addr=0,len=16,m_ready=1 -> m_data=ROM[0..15] in order,
//    16 back-to-back beats, first m_valid 2 edges after start, m_last on 16th,
//    done one cycle after it.
//  2 Wrap: start_addr=14,len=4 -> rom_addr 14,15,0,1; beats ROM[14],ROM[15],
//    ROM[0],ROM[1]; m_last on ROM[1].
//  3 Backpressure: len=16, m_ready random 50% -> all 16 words exactly once in
//    order; buffer count never >BUF_DEPTH; m_data stable while valid & !ready.
//  4 len=0 -> busy for 1 cycle, done pulse next cycle, m_valid never high,
//    rom_addr unchanged.
//  5 start pulsed while busy (len=8 run) -> ignored; exactly 8 beats delivered.
//  6 rst asserted mid-run after 5 beats -> outputs reset immediately (async),
//    no stale beat after release; new start len=3 at addr 2 -> ROM[2..4].

Source files
------------

// File: rtl/rom_stream_reader.sv
// Walks a range of ROM addresses and turns the synchronous-read ROM output into a
// valid/ready stream, using a credit-checked FIFO to absorb the one-cycle read latency.
module rom_stream_reader #(
   parameter int AW        = 4,
   parameter int DW        = 8,
   parameter int BUF_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [AW:0]   len_q;
   logic [AW:0]   issued_q;
   logic          issue_q;
   logic          issue_last_q;
   logic          ret_valid_q;
   logic          ret_last_q;
   logic [DW-1:0] buf_data [BUF_DEPTH];
   logic          buf_last [BUF_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] buf_count;
   logic [CW:0]   occupancy;

   logic accept_run;
   logic issue_next;
   logic pop;
   logic push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop     = m_valid & m_ready;
   assign push    = ret_valid_q;
   assign m_valid = (buf_count != '0);
   assign m_data  = buf_data[rd_ptr];
   assign m_last  = buf_last[rd_ptr];
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   // Words already buffered plus those still in the ROM pipe, after this cycle's pop
   assign occupancy = {1'b0, buf_count} + (CW+1)'(issue_q) + (CW+1)'(ret_valid_q)
                      - (CW+1)'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept_run = 1'b0;
      issue_next = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept_run = (len != '0);
               state_next = (len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            issue_next = (issued_q < len_q) && (occupancy < (CW+1)'(BUF_DEPTH));
            if (pop && m_last) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address issue: the tag for the final word rides along with the read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr     <= '0;
         issue_q      <= 1'b0;
         issue_last_q <= 1'b0;
         issued_q     <= '0;
         len_q        <= '0;
      end else if (accept_run) begin
         rom_addr     <= start_addr;
         issue_q      <= 1'b1;
         issue_last_q <= (len == (AW+1)'(1));
         issued_q     <= (AW+1)'(1);
         len_q        <= len;
      end else if (issue_next) begin
         rom_addr     <= rom_addr + AW'(1);
         issue_q      <= 1'b1;
         issue_last_q <= ((issued_q + (AW+1)'(1)) == len_q);
         issued_q     <= issued_q + (AW+1)'(1);
      end else begin
         issue_q      <= 1'b0;
         issue_last_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ret_valid_q <= 1'b0;
         ret_last_q  <= 1'b0;
      end else begin
         ret_valid_q <= issue_q;
         ret_last_q  <= issue_last_q;
      end
   end

   // Output FIFO; the credit check in the issue path keeps it from overflowing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
         end
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         buf_count <= '0;
      end else begin
         if (push) begin
            buf_data[wr_ptr] <= rom_data;
            buf_last[wr_ptr] <= ret_last_q;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         buf_count <= buf_count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: a behavioural sync-read ROM feeds the DUT and
// the received stream is compared with the ROM contents it should have walked.
module tb_rom_stream_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] start_addr;
   logic [4:0] len;
   logic       busy;
   logic       done;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;

   logic [7:0] rom_mem [16];

   int checks;
   int failures;

   logic [7:0] got_data [$];
   logic       got_last [$];
   int         first_valid_k;
   int         first_beat_k;
   int         last_beat_k;
   int         done_k;
   int         stab_viol;
   int         max_count;
   int         valid_seen;
   logic       busy_k0;
   logic [3:0] addr_trace [4];

   rom_stream_reader #(.AW(4), .DW(8), .BUF_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port ROM with registered read data
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Launch one transfer and record every beat; poke_k re-pulses start mid-run
   task automatic applyStimulus(input logic [3:0] sa, input logic [4:0] ln,
                                input int ready_pct, input int poke_k,
                                input int abort_beats);
      bit         hold_prev;
      bit         finished;
      logic [7:0] data_prev;
      got_data.delete();
      got_last.delete();
      first_valid_k = -1;
      first_beat_k  = -1;
      last_beat_k   = -1;
      done_k        = -1;
      stab_viol     = 0;
      max_count     = 0;
      busy_k0       = 1'b0;
      hold_prev     = 1'b0;
      finished      = 1'b0;
      data_prev     = '0;
      start         = 1'b1;
      start_addr    = sa;
      len           = ln;
      for (int k = 0; k < 200 && !finished; k++) begin
         @(negedge clk);
         start = (k == poke_k);
         if (k == poke_k) begin
            start_addr = 4'd9;
            len        = 5'd5;
         end
         m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
         if (k < 4) addr_trace[k] = rom_addr;
         if (k == 0) busy_k0 = busy;
         if (int'(dut.buf_count) > max_count) max_count = int'(dut.buf_count);
         if (hold_prev && (!m_valid || m_data !== data_prev)) stab_viol++;
         if (done) begin
            done_k   = k;
            finished = 1'b1;
         end else begin
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (m_valid && m_ready) begin
               got_data.push_back(m_data);
               got_last.push_back(m_last);
               if (first_beat_k < 0) first_beat_k = k;
               last_beat_k = k;
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
            if (abort_beats > 0 && got_data.size() == abort_beats) finished = 1'b1;
         end
      end
      start = 1'b0;
      checkOutput("transfer_finished", {31'd0, finished}, 32'd1);
   endtask

   task automatic checkBeats(input string tag, input int sa, input int n);
      int cnt;
      cnt = (got_data.size() < n) ? got_data.size() : n;
      checkOutput({tag, "_beats"}, got_data.size(), n);
      for (int i = 0; i < cnt; i++) begin
         checkOutput({tag, "_data"}, {24'd0, got_data[i]}, {24'd0, rom_mem[(sa + i) % 16]});
         checkOutput({tag, "_last"}, {31'd0, got_last[i]}, {31'd0, (i == n - 1)});
      end
   endtask

   task automatic checkIdleAfter(input string tag, input logic [3:0] exp_addr);
      @(negedge clk);
      checkOutput({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_done_low"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_addr_hold"}, {28'd0, rom_addr}, {28'd0, exp_addr});
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      m_ready    = 1'b0;
      for (int i = 0; i < 16; i++) rom_mem[i] = 8'((i * 37 + 11) % 256);

      repeat (2) @(negedge clk);
      checkOutput("rst_busy",   {31'd0, busy},    32'd0);
      checkOutput("rst_done",   {31'd0, done},    32'd0);
      checkOutput("rst_addr",   {28'd0, rom_addr}, 32'd0);
      checkOutput("rst_valid",  {31'd0, m_valid}, 32'd0);
      checkOutput("rst_last",   {31'd0, m_last},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] full sweep");
      applyStimulus(4'd0, 5'd16, 100, -1, 0);
      checkBeats("sweep", 0, 16);
      checkOutput("sweep_first_valid", first_valid_k, 32'd2);
      checkOutput("sweep_back_to_back", last_beat_k - first_beat_k, 32'd15);
      checkOutput("sweep_done_after_last", done_k, last_beat_k + 1);
      checkIdleAfter("sweep", 4'd15);

      $display("[TB] address wrap");
      applyStimulus(4'd14, 5'd4, 100, -1, 0);
      checkOutput("wrap_addr0", {28'd0, addr_trace[0]}, 32'd14);
      checkOutput("wrap_addr1", {28'd0, addr_trace[1]}, 32'd15);
      checkOutput("wrap_addr2", {28'd0, addr_trace[2]}, 32'd0);
      checkOutput("wrap_addr3", {28'd0, addr_trace[3]}, 32'd1);
      checkBeats("wrap", 14, 4);
      checkIdleAfter("wrap", 4'd1);

      $display("[TB] random backpressure");
      applyStimulus(4'd5, 5'd16, 50, -1, 0);
      checkBeats("bp", 5, 16);
      checkOutput("bp_stable_while_stalled", stab_viol, 32'd0);
      checkOutput("bp_buf_bounded", {31'd0, (max_count <= 4)}, 32'd1);
      m_ready = 1'b1;
      checkIdleAfter("bp", 4'd4);

      $display("[TB] zero length");
      applyStimulus(4'd7, 5'd0, 100, -1, 0);
      checkOutput("len0_done_k", done_k, 32'd0);
      checkOutput("len0_busy", {31'd0, busy_k0}, 32'd1);
      checkOutput("len0_no_valid", {31'd0, (first_valid_k < 0)}, 32'd1);
      checkOutput("len0_beats", got_data.size(), 32'd0);
      checkOutput("len0_addr", {28'd0, addr_trace[0]}, 32'd4);
      checkIdleAfter("len0", 4'd4);

      $display("[TB] start while busy");
      applyStimulus(4'd3, 5'd8, 100, 3, 0);
      checkBeats("busy_start", 3, 8);
      checkIdleAfter("busy_start", 4'd10);

      $display("[TB] reset mid-run");
      applyStimulus(4'd0, 5'd16, 100, -1, 5);
      checkOutput("abort_beats", got_data.size(), 32'd5);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst_valid", {31'd0, m_valid}, 32'd0);
      checkOutput("arst_busy",  {31'd0, busy},    32'd0);
      checkOutput("arst_addr",  {28'd0, rom_addr}, 32'd0);
      checkOutput("arst_done",  {31'd0, done},    32'd0);
      checkOutput("arst_last",  {31'd0, m_last},  32'd0);
      @(negedge clk);
      rst        = 1'b0;
      valid_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (m_valid) valid_seen++;
      end
      checkOutput("arst_no_stale_beat", valid_seen, 32'd0);
      applyStimulus(4'd2, 5'd3, 100, -1, 0);
      checkBeats("post_rst", 2, 3);
      checkIdleAfter("post_rst", 4'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
